// File: rtl/dcpu16_alu_seq.sv
// Request/response sequencer in front of the DCPU16 ALU; DIV/MOD run on a local restoring divider.
// Define DCPU16_ALUSEQ_DIV_EN to build the divider; otherwise DIV/MOD return zero results.
module dcpu16_alu_seq #(
  parameter logic [1:0]  PHA_IDLE  = 2'd3,
  parameter int unsigned DIV_RADIX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld_i,
  output logic        req_rdy_o,
  input  logic [3:0]  req_opc_i,
  input  logic [15:0] req_a_i,
  input  logic [15:0] req_b_i,
  output logic        rsp_vld_o,
  input  logic        rsp_rdy_i,
  output logic [15:0] rsp_r_o,
  output logic [15:0] rsp_o_o,
  output logic        rsp_cc_o,
  output logic [3:0]  alu_opc_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic        alu_ena_o,
  output logic [1:0]  alu_pha_o,
  input  logic [15:0] alu_r_i,
  input  logic [15:0] alu_o_i,
  input  logic        alu_cc_i
);

  if (DIV_RADIX != 1 && DIV_RADIX != 2) begin : g_bad_radix
    $error("dcpu16_alu_seq: DIV_RADIX must be 1 or 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDiv, StResp} state_e;

  localparam logic [3:0] OpcDiv = 4'h5;
  localparam logic [3:0] OpcMod = 4'h6;

  state_e      state_q, state_d;
  logic [3:0]  opc_q;
  logic [15:0] a_q, b_q;
  logic        accept;
  logic        req_is_div;
  logic        op_is_div;
  logic        div_done;

  assign accept     = req_vld_i & req_rdy_o;
  assign req_is_div = (req_opc_i == OpcDiv) || (req_opc_i == OpcMod);
  assign op_is_div  = (opc_q == OpcDiv) || (opc_q == OpcMod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q <= req_opc_i;
        a_q   <= req_a_i;
        b_q   <= req_b_i;
      end
    end
  end

`ifdef DCPU16_ALUSEQ_DIV_EN
  localparam int unsigned DivSteps = 32 / DIV_RADIX;
  localparam logic [4:0]  CntLast  = 5'(DivSteps - 1);
  // After this step 16 quotient bits are resolved and the partial remainder equals a % b.
  localparam logic [4:0]  CntHalf  = 5'(DivSteps / 2 - 1);

  logic        op_is_mod;
  logic [16:0] rem_q, rem_d, rem_s;
  logic [31:0] quo_q, quo_d, quo_s;
  logic [15:0] mod_q, mod_d;
  logic [4:0]  cnt_q, cnt_d;

  assign op_is_mod = (opc_q == OpcMod);
  assign div_done  = (b_q == 16'h0) || (cnt_q == CntLast);

  // quo holds the shifting dividend; quotient bits enter at the bottom.
  always_comb begin
    rem_s = rem_q;
    quo_s = quo_q;
    for (int unsigned i = 0; i < DIV_RADIX; i++) begin
      rem_s = {rem_s[15:0], quo_s[31]};
      quo_s = {quo_s[30:0], 1'b0};
      if (rem_s >= {1'b0, b_q}) begin
        rem_s    = rem_s - {1'b0, b_q};
        quo_s[0] = 1'b1;
      end
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    mod_d = mod_q;
    cnt_d = cnt_q;
    if (accept) begin
      rem_d = '0;
      quo_d = {req_a_i, 16'h0};
      mod_d = '0;
      cnt_d = '0;
    end else if (state_q == StDiv) begin
      if (b_q == 16'h0) begin
        quo_d = '0;
        mod_d = '0;
      end else begin
        rem_d = rem_s;
        quo_d = quo_s;
        if (cnt_q == CntHalf) begin
          mod_d = rem_s[15:0];
        end
        if (cnt_q != CntLast) begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      mod_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      mod_q <= mod_d;
      cnt_q <= cnt_d;
    end
  end
`else
  // Without a divider DIV/MOD still spend one cycle in StDiv so the response lands at T+2.
  assign div_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = req_is_div ? StDiv : StIssue;
        end
      end
      StIssue: state_d = StResp;
      StDiv: begin
        if (div_done) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_rdy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_rdy_o = (state_q == StIdle);
  assign rsp_vld_o = (state_q == StResp);
  assign alu_ena_o = (state_q == StIssue);
  assign alu_pha_o = alu_ena_o ? 2'd0 : PHA_IDLE;
  assign alu_opc_o = opc_q;
  assign alu_a_o   = a_q;
  assign alu_b_o   = b_q;

  // ALU results are safe to pass straight through: alu_ena stays low until the next issue.
  always_comb begin
    rsp_r_o  = 16'h0;
    rsp_o_o  = 16'h0;
    rsp_cc_o = 1'b1;
    if (state_q == StResp) begin
      if (op_is_div) begin
`ifdef DCPU16_ALUSEQ_DIV_EN
        rsp_r_o = op_is_mod ? mod_q : quo_q[31:16];
        rsp_o_o = op_is_mod ? alu_o_i : quo_q[15:0];
`endif
      end else begin
        rsp_r_o  = alu_r_i;
        rsp_o_o  = alu_o_i;
        rsp_cc_o = alu_cc_i;
      end
    end
  end

endmodule

// File: tb/tb_dcpu16_alu_seq.sv
// Bench for dcpu16_alu_seq: behavioural ALU on the alu_* side, arithmetic reference model for
// responses, directed spec cases followed by randomized ops.
module tb_dcpu16_alu_seq;

  localparam logic [1:0]  PhaIdle = 2'd3;
  localparam int unsigned Radix   = 1;
`ifdef DCPU16_ALUSEQ_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] o;
    logic        cc;
  } alu_res_t;

  logic        clk;
  logic        rst;
  logic        req_vld, req_rdy;
  logic [3:0]  req_opc;
  logic [15:0] req_a, req_b;
  logic        rsp_vld, rsp_rdy;
  logic [15:0] rsp_r, rsp_o;
  logic        rsp_cc;
  logic [3:0]  alu_opc;
  logic [15:0] alu_a, alu_b;
  logic        alu_ena;
  logic [1:0]  alu_pha;
  logic [15:0] alu_r, alu_o;
  logic        alu_cc;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_res_t    m_res = {16'h0, 16'h0, 1'b1};
  logic [15:0] ref_r = 16'h0;
  logic [15:0] ref_o = 16'h0;
  logic [15:0] obs_r, obs_o;
  logic        obs_cc;

  dcpu16_alu_seq #(
    .PHA_IDLE (PhaIdle),
    .DIV_RADIX(Radix)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld_i(req_vld),
    .req_rdy_o(req_rdy),
    .req_opc_i(req_opc),
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .rsp_vld_o(rsp_vld),
    .rsp_rdy_i(rsp_rdy),
    .rsp_r_o  (rsp_r),
    .rsp_o_o  (rsp_o),
    .rsp_cc_o (rsp_cc),
    .alu_opc_o(alu_opc),
    .alu_a_o  (alu_a),
    .alu_b_o  (alu_b),
    .alu_ena_o(alu_ena),
    .alu_pha_o(alu_pha),
    .alu_r_i  (alu_r),
    .alu_o_i  (alu_o),
    .alu_cc_i (alu_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DCPU16 basic-op semantics; regR/regO persist when an op does not define them.
  function automatic alu_res_t alu_calc(input logic [3:0] opc, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] r_in,
                                        input logic [15:0] o_in);
    alu_res_t    res;
    logic [31:0] w;
    res = {r_in, o_in, 1'b1};
    case (opc)
      4'h1: res.r = b;
      4'h2: begin
        w     = {16'h0, a} + {16'h0, b};
        res.r = w[15:0];
        res.o = w[16] ? 16'h0001 : 16'h0000;
      end
      4'h3: begin
        res.r = a - b;
        res.o = (a < b) ? 16'hFFFF : 16'h0000;
      end
      4'h4: begin
        w     = {16'h0, a} * {16'h0, b};
        res.r = w[15:0];
        res.o = w[31:16];
      end
      4'h5, 4'h6: begin
        // Poison: DIV/MOD must never be issued to the ALU.
        res.r = 16'hDEAD;
        res.o = 16'hBEEF;
      end
      4'h7: begin
        w     = {16'h0, a} << b;
        res.r = w[15:0];
        res.o = w[31:16];
      end
      4'h8: begin
        w     = {a, 16'h0} >> b;
        res.r = a >> b;
        res.o = w[15:0];
      end
      4'h9: res.r = a & b;
      4'hA: res.r = a | b;
      4'hB: res.r = a ^ b;
      4'hC: res.cc = (a == b);
      4'hD: res.cc = (a != b);
      4'hE: res.cc = (a > b);
      4'hF: res.cc = ((a & b) != 16'h0);
      default: ;
    endcase
    return res;
  endfunction

  always @(posedge clk) begin
    if (alu_ena && alu_pha == 2'd0) begin
      m_res <= alu_calc(alu_opc, alu_a, alu_b, m_res.r, m_res.o);
    end
  end

  assign alu_r  = m_res.r;
  assign alu_o  = m_res.o;
  assign alu_cc = m_res.cc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                       input int hold);
    int          k;
    int          exp_lat;
    logic [15:0] er, eo;
    logic        ecc;
    logic [31:0] q32;
    alu_res_t    res;
    bit          is_div;

    is_div = (opc == 4'h5) || (opc == 4'h6);
    if (is_div) begin
      er      = 16'h0;
      eo      = 16'h0;
      ecc     = 1'b1;
      exp_lat = 2;
      if (DivEn && b != 16'h0) begin
        exp_lat = 1 + 32 / Radix;
        q32     = {a, 16'h0} / {16'h0, b};
        if (opc == 4'h5) begin
          er = a / b;
          eo = q32[15:0];
        end else begin
          er = a % b;
          eo = ref_o;
        end
      end else if (DivEn && opc == 4'h6) begin
        eo = ref_o;
      end
    end else begin
      res     = alu_calc(opc, a, b, ref_r, ref_o);
      er      = res.r;
      eo      = res.o;
      ecc     = res.cc;
      ref_r   = res.r;
      ref_o   = res.o;
      exp_lat = 2;
    end

    @(negedge clk);
    k = 0;
    while (!req_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("req_rdy_idle", 64'(req_rdy), 64'(1));
    req_vld = 1'b1;
    req_opc = opc;
    req_a   = a;
    req_b   = b;
    @(negedge clk);
    req_vld = 1'b0;
    req_opc = 4'($urandom);
    req_a   = 16'($urandom);
    req_b   = 16'($urandom);
    check("issue_ena", 64'(alu_ena), is_div ? 64'(0) : 64'(1));
    check("issue_pha", 64'(alu_pha), is_div ? 64'(PhaIdle) : 64'(0));
    if (!is_div) begin
      check("issue_bus", {28'h0, alu_opc, alu_a, alu_b}, {28'h0, opc, a, b});
    end
    k = 1;
    while (!rsp_vld && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 64'(k), 64'(exp_lat));
    obs_r  = rsp_r;
    obs_o  = rsp_o;
    obs_cc = rsp_cc;
    check("rsp_r", 64'(rsp_r), 64'(er));
    check("rsp_o", 64'(rsp_o), 64'(eo));
    check("rsp_cc", 64'(rsp_cc), 64'(ecc));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {29'h0, rsp_vld, req_rdy, rsp_cc, rsp_r, rsp_o},
            {29'h0, 1'b1, 1'b0, ecc, er, eo});
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    check("after_handshake", {62'h0, req_rdy, rsp_vld}, {62'h0, 2'b10});
  endtask

  initial begin
    logic [3:0]  opc;
    logic [15:0] a, b;
    int          k;

    rst     = 1'b1;
    req_vld = 1'b0;
    req_opc = 4'h0;
    req_a   = 16'h0;
    req_b   = 16'h0;
    rsp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hs", {61'h0, req_rdy, rsp_vld, alu_ena}, {61'h0, 3'b100});
    check("reset_pha", 64'(alu_pha), 64'(PhaIdle));
    check("reset_bus", {28'h0, alu_opc, alu_a, alu_b}, 64'h0);
    check("reset_rsp", {31'h0, rsp_cc, rsp_r, rsp_o}, {31'h0, 1'b1, 32'h0});
    rst = 1'b0;

    do_op(4'h2, 16'hFFFF, 16'h0001, 0);
    check("add_const", {31'h0, obs_cc, obs_r, obs_o}, {31'h0, 1'b1, 16'h0000, 16'h0001});
    do_op(4'h5, 16'h0007, 16'h0002, 0);
    check("div_const", {32'h0, obs_r, obs_o},
          DivEn ? {32'h0, 16'h0003, 16'h8000} : 64'h0);
    do_op(4'h6, 16'h0007, 16'h0002, 1);
    check("mod_const", {32'h0, obs_r, obs_o},
          DivEn ? {32'h0, 16'h0001, 16'h0001} : 64'h0);
    do_op(4'h5, 16'h1234, 16'h0000, 0);
    check("div0_const", {32'h0, obs_r, obs_o}, 64'h0);
    do_op(4'h6, 16'h1234, 16'h0000, 0);
    do_op(4'hC, 16'h0005, 16'h0005, 0);
    check("ife_cc", 64'(obs_cc), 64'(1));
    do_op(4'hE, 16'h0003, 16'h0009, 0);
    check("ifg_cc", 64'(obs_cc), 64'(0));
    do_op(4'h3, 16'h0000, 16'h0001, 5);
    check("sub_const", {32'h0, obs_r, obs_o}, {32'h0, 16'hFFFF, 16'hFFFF});
    do_op(4'h5, 16'hFFFF, 16'h0001, 0);
    do_op(4'h6, 16'hABCD, 16'hFFFF, 2);

    // Reset during the tenth divider cycle discards the op.
    @(negedge clk);
    req_vld = 1'b1;
    req_opc = 4'h5;
    req_a   = 16'h9999;
    req_b   = 16'h0003;
    @(negedge clk);
    req_vld = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_div", {61'h0, req_rdy, rsp_vld, alu_ena}, {61'h0, 3'b100});
    check("rst_rsp", {31'h0, rsp_cc, rsp_r, rsp_o}, {31'h0, 1'b1, 32'h0});
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_vld) k++;
    end
    check("rst_no_rsp", 64'(k), 64'(0));
    do_op(4'h2, 16'h1111, 16'h2222, 0);
    check("add_after_rst", {32'h0, obs_r, obs_o}, {32'h0, 16'h3333, 16'h0000});

    for (int n = 0; n < 40; n++) begin
      opc = 4'($urandom_range(1, 15));
      a   = 16'($urandom);
      b   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'h0;
      if (opc == 4'h7 || opc == 4'h8) b = 16'($urandom_range(0, 20));
      if (opc >= 4'hC && $urandom_range(0, 2) == 0) b = a;
      if ((opc == 4'h5 || opc == 4'h6) && $urandom_range(0, 1) == 0) b = 16'($urandom_range(1, 9));
      do_op(opc, a, b, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
